// File: rtl/tge_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the 10GbE core TX interface.
// One frame per grant, one register stage to the core, per-port frame counters.
module tge_tx_arbiter #(
    parameter int N_PORTS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_PORTS-1:0]    in_req,
    input  logic [N_PORTS-1:0]    in_valid,
    input  logic [N_PORTS-1:0]    in_eof,
    input  logic [64*N_PORTS-1:0] in_data,
    input  logic [32*N_PORTS-1:0] in_dest_ip,
    input  logic [16*N_PORTS-1:0] in_dest_port,
    output logic [N_PORTS-1:0]    in_ready,
    output logic                  tx_valid,
    output logic                  tx_end_of_frame,
    output logic [63:0]           tx_data,
    output logic [31:0]           tx_dest_ip,
    output logic [15:0]           tx_dest_port,
    input  logic                  tx_afull,
    input  logic                  tx_overflow,
    output logic [2:0]            grant,
    output logic                  busy,
    output logic [32*N_PORTS-1:0] frame_cnt,
    output logic                  ovf_seen,
    output logic [2:0]            ovf_port
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_q, last_d;
    logic        sel_found;
    logic [2:0]  sel_idx;
    logic        g_valid, g_eof;
    logic [63:0] g_data;
    logic [31:0] g_ip;
    logic [15:0] g_port;
    logic        accept;
    logic [31:0] cnt_q [N_PORTS];

    // Round-robin pick: lowest requester above last, else lowest requester overall.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (in_req[j]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(j);
            end
        end
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (in_req[j] && (3'(j) > last_q)) begin
                sel_idx = 3'(j);
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_eof   = 1'b0;
        g_data  = '0;
        g_ip    = '0;
        g_port  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = in_valid[i];
                g_eof   = in_eof[i];
                g_data  = in_data[64*i +: 64];
                g_ip    = in_dest_ip[32*i +: 32];
                g_port  = in_dest_port[16*i +: 16];
            end
        end
    end

    // Backpressure acts combinationally so at most one registered word trails tx_afull.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            in_ready[i] = (state_q == XFER) && (grant_q == 3'(i)) && !tx_afull;
        end
    end

    assign accept = (state_q == XFER) && g_valid && !tx_afull;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = XFER;
                    grant_d = sel_idx;
                    last_d  = sel_idx;
                end
            end
            XFER: begin
                if (accept && g_eof) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            last_q          <= 3'(N_PORTS - 1);
            tx_valid        <= 1'b0;
            tx_end_of_frame <= 1'b0;
            tx_data         <= '0;
            tx_dest_ip      <= '0;
            tx_dest_port    <= '0;
            ovf_seen        <= 1'b0;
            ovf_port        <= '0;
            // NOTE: the counter array is a bank of flops, not a RAM, so it is cleared here.
            for (int i = 0; i < N_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_q          <= last_d;
            tx_valid        <= accept;
            tx_end_of_frame <= accept && g_eof;
            if (accept) begin
                tx_data      <= g_data;
                tx_dest_ip   <= g_ip;
                tx_dest_port <= g_port;
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (accept && g_eof && (grant_q == 3'(i))) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
            // Only the first overflow is attributed; later ones leave the capture alone.
            if (tx_overflow && !ovf_seen) begin
                ovf_seen <= 1'b1;
                ovf_port <= grant_q;
            end
        end
    end

    for (genvar i = 0; i < N_PORTS; i++) begin : g_cnt
        assign frame_cnt[32*i +: 32] = cnt_q[i];
    end

    assign grant = grant_q;
    assign busy  = (state_q == XFER);

endmodule

// File: tb/tb_tge_tx_arbiter.sv
// Self-checking bench for tge_tx_arbiter: per-port frame sources, a scoreboard
// of expected TX words in grant order, and directed multi-cycle corner cases.
module tb_tge_tx_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [63:0] data;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] dport;
        logic [2:0]  pidx;
    } word_t;

    typedef struct {
        int          port;
        int          len;
        logic [63:0] base;
    } frame_vec_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_req;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_eof;
    logic [64*N-1:0] in_data;
    logic [32*N-1:0] in_dest_ip;
    logic [16*N-1:0] in_dest_port;
    logic [N-1:0]    in_ready;
    logic            tx_valid;
    logic            tx_end_of_frame;
    logic [63:0]     tx_data;
    logic [31:0]     tx_dest_ip;
    logic [15:0]     tx_dest_port;
    logic            tx_afull;
    logic            tx_overflow;
    logic [2:0]      grant;
    logic            busy;
    logic [32*N-1:0] frame_cnt;
    logic            ovf_seen;
    logic [2:0]      ovf_port;

    tge_tx_arbiter #(.N_PORTS(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_req          (in_req),
        .in_valid        (in_valid),
        .in_eof          (in_eof),
        .in_data         (in_data),
        .in_dest_ip      (in_dest_ip),
        .in_dest_port    (in_dest_port),
        .in_ready        (in_ready),
        .tx_valid        (tx_valid),
        .tx_end_of_frame (tx_end_of_frame),
        .tx_data         (tx_data),
        .tx_dest_ip      (tx_dest_ip),
        .tx_dest_port    (tx_dest_port),
        .tx_afull        (tx_afull),
        .tx_overflow     (tx_overflow),
        .grant           (grant),
        .busy            (busy),
        .frame_cnt       (frame_cnt),
        .ovf_seen        (ovf_seen),
        .ovf_port        (ovf_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    word_t      src_mem [N][64];
    int         src_head [N];
    int         src_tail [N];
    word_t      exp_q [$];
    int         exp_cnt [N];
    logic [N-1:0] acc;
    bit         req_auto;
    bit         sb_en;
    int         n_popped;
    frame_vec_t t1 [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit any_pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (src_head[i] < src_tail[i]) begin
                in_valid[i]            = 1'b1;
                in_eof[i]              = src_mem[i][src_head[i]].eof;
                in_data[64*i +: 64]    = src_mem[i][src_head[i]].data;
                in_dest_ip[32*i +: 32] = src_mem[i][src_head[i]].ip;
                in_dest_port[16*i +: 16] = src_mem[i][src_head[i]].dport;
            end else begin
                in_valid[i] = 1'b0;
                in_eof[i]   = 1'b0;
            end
            if (req_auto) in_req[i] = (src_head[i] < src_tail[i]);
        end
    endtask

    task automatic load_frame(input int port, input int len, input logic [63:0] base, input bit push);
        word_t w;
        if (src_head[port] == src_tail[port]) begin
            src_head[port] = 0;
            src_tail[port] = 0;
        end
        for (int k = 0; k < len; k++) begin
            w.data  = base + 64'(k);
            w.eof   = (k == len - 1);
            w.ip    = 32'hC0A8_0100 + 32'(port);
            w.dport = 16'd5000 + 16'(port);
            w.pidx  = 3'(port);
            src_mem[port][src_tail[port]] = w;
            src_tail[port]++;
            if (push) exp_q.push_back(w);
        end
        if (push) exp_cnt[port]++;
        refresh();
    endtask

    // Sample mid-cycle: note which ports hand over a word at the next edge and score TX output.
    task automatic mon();
        word_t e;
        @(negedge clk);
        acc = in_valid & in_ready;
        if (sb_en && tx_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got %h expected none", tx_data);
            end else begin
                e = exp_q.pop_front();
                n_popped++;
                check("tx_data", tx_data, e.data);
                check("tx_eof", 64'(tx_end_of_frame), 64'(e.eof));
                check("tx_dest_ip", 64'(tx_dest_ip), 64'(e.ip));
                check("tx_dest_port", 64'(tx_dest_port), 64'(e.dport));
                check("tx_grant", 64'(grant), 64'(e.pidx));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) src_head[i]++;
        end
        refresh();
    endtask

    task automatic step();
        mon();
        adv();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || any_pending()) && n < budget) begin
            step();
            n++;
        end
        repeat (2) step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_cnt;
        int last_v;
        int pulses;
        int n;

        rst = 1'b0; in_req = '1; in_valid = '0; in_eof = '0; in_data = '0;
        in_dest_ip = '0; in_dest_port = '0; tx_afull = 1'b0; tx_overflow = 1'b0;
        req_auto = 1'b0; sb_en = 1'b1; n_popped = 0; acc = '0;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0; src_tail[i] = 0; exp_cnt[i] = 0;
        end

        // Reset state, with requests present to show they are held off.
        repeat (2) step();
        mon();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_eof", 64'(tx_end_of_frame), 64'd0);
        check("rst_tx_data", tx_data, 64'd0);
        check("rst_tx_ip", 64'(tx_dest_ip), 64'd0);
        check("rst_tx_port", 64'(tx_dest_port), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_ovf_seen", 64'(ovf_seen), 64'd0);
        check("rst_ovf_port", 64'(ovf_port), 64'd0);
        rst = 1'b1;
        in_req = '0;
        adv();

        // Round robin across all ports, 3-word frames; port 0 comes round again.
        t1[0] = '{0, 3, 64'h0000_0000_0000_0100};
        t1[1] = '{1, 3, 64'h1111_0000_0000_0200};
        t1[2] = '{2, 3, 64'h2222_0000_0000_0300};
        t1[3] = '{3, 3, 64'h3333_0000_0000_0400};
        t1[4] = '{0, 3, 64'h0000_5555_0000_0500};
        req_auto = 1'b1;
        for (int f = 0; f < 5; f++) begin
            load_frame(t1[f].port, t1[f].len, t1[f].base, 1'b1);
        end
        drain("t1_drain", 200);
        for (int i = 0; i < N; i++) begin
            check("t1_frame_cnt", 64'(frame_cnt[32*i +: 32]), 64'(exp_cnt[i]));
        end

        // Port 2, 8 words, tx_afull high in XFER cycles 3..5.
        load_frame(2, 8, 64'hA2A2_0000_0000_0000, 1'b1);
        n_popped = 0;
        step();
        for (int c = 1; c <= 11; c++) begin
            tx_afull = (c >= 3 && c <= 5);
            mon();
            check("t2_in_ready", 64'(in_ready), tx_afull ? 64'd0 : 64'd4);
            adv();
        end
        tx_afull = 1'b0;
        drain("t2_drain", 50);
        check("t2_words", 64'(n_popped), 64'd8);

        // Port 1 holds its grant while requests change under it.
        req_auto = 1'b0;
        in_req = '0;
        load_frame(1, 5, 64'hB1B1_0000_0000_0000, 1'b1);
        load_frame(3, 2, 64'hB3B3_0000_0000_0000, 1'b1);
        in_req = 4'b0010;
        step();
        step();
        in_req = 4'b1000;
        n = 0;
        while (src_head[3] == 0 && n < 50) begin
            step();
            n++;
        end
        in_req = '0;
        drain("t3_drain", 50);
        check("t3_grant", 64'(grant), 64'd3);
        req_auto = 1'b1;
        refresh();

        // Back-to-back single-word frames on port 0.
        base_cnt = exp_cnt[0];
        for (int f = 0; f < 4; f++) begin
            load_frame(0, 1, 64'hC0C0_0000_0000_0010 + 64'(f * 16), 1'b1);
        end
        last_v = -1;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            mon();
            if (tx_valid) begin
                pulses++;
                if (last_v >= 0) check("t4_gap", 64'(c - last_v), 64'd2);
                check("t4_cnt0", 64'(frame_cnt[31:0]), 64'(base_cnt + pulses));
                last_v = c;
            end
            adv();
        end
        check("t4_pulses", 64'(pulses), 64'd4);
        check("t4_left", 64'(exp_q.size()), 64'd0);

        // Overflow attribution: first on port 2, later on port 0 ignored.
        check("t5_ovf_pre", 64'(ovf_seen), 64'd0);
        load_frame(2, 4, 64'hD2D2_0000_0000_0000, 1'b1);
        step();
        tx_overflow = 1'b1;
        step();
        tx_overflow = 1'b0;
        mon();
        check("t5_ovf_seen", 64'(ovf_seen), 64'd1);
        check("t5_ovf_port", 64'(ovf_port), 64'd2);
        adv();
        drain("t5_drain_a", 50);
        load_frame(0, 3, 64'hD0D0_0000_0000_0000, 1'b1);
        step();
        tx_overflow = 1'b1;
        mon();
        check("t5_grant0", 64'(grant), 64'd0);
        adv();
        tx_overflow = 1'b0;
        drain("t5_drain_b", 50);
        check("t5_ovf_seen2", 64'(ovf_seen), 64'd1);
        check("t5_ovf_port2", 64'(ovf_port), 64'd2);

        // Reset in the middle of a port 1 frame.
        sb_en = 1'b0;
        load_frame(1, 6, 64'hE1E1_0000_0000_0000, 1'b0);
        step();
        step();
        step();
        check("t6_busy_pre", 64'(busy), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_head[i] = 0; src_tail[i] = 0; exp_cnt[i] = 0;
        end
        refresh();
        mon();
        check("t6_tx_valid", 64'(tx_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t6_ovf_seen", 64'(ovf_seen), 64'd0);
        check("t6_ovf_port", 64'(ovf_port), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        adv();
        sb_en = 1'b1;
        load_frame(0, 2, 64'hF0F0_0000_0000_0000, 1'b1);
        load_frame(1, 2, 64'hF1F1_0000_0000_0000, 1'b1);
        drain("t6_drain", 50);
        check("t6_cnt0", 64'(frame_cnt[31:0]), 64'(exp_cnt[0]));
        check("t6_cnt1", 64'(frame_cnt[63:32]), 64'(exp_cnt[1]));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
